tcm_axis_readout: RTL

- Downstream neighbour of the TCM capture stage.
- After software issues a start, it reads a contiguous range of the 32x32 TCM BRAM through its read port and streams it out as one AXI-Stream master packet, with TLAST on the final word.
- Handles the BRAM's one-cycle read latency and full TREADY backpressure using a 2-entry output FIFO.
- Reports busy/done status back to the control register file.

---
 rtl/tcm_axis_readout.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tcm_axis_readout.sv
// Purpose: after a software start, reads TCM words 0..last_addr and streams them as one AXI-Stream packet.
// Latency: start sampled at edge E0 -> first read issued right after E0, first TVALID right after E0+2 edges.
// Backpressure: full TREADY stall support; a read is issued only when the 2-entry output FIFO has room for it.
module tcm_axis_readout #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_TCM_ADDR_WIDTH     = 5
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESETN,
    input  logic [31:0]                     USR_tcm_control,
    output logic                            tcm_rd_en,
    output logic [C_TCM_ADDR_WIDTH-1:0]     tcm_rd_addr,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] tcm_rd_data,
    output logic                            tcm_busy,
    output logic                            tcm_done,
    output logic                            M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY
);
    localparam int DW = C_M_AXIS_TDATA_WIDTH;
    localparam int AW = C_TCM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic          start_q, start_arm, start_pulse, start_accept;
    logic [AW-1:0] last_addr, rd_ptr, out_idx;
    logic          rd_exhausted, inflight, issuing;
    logic [DW-1:0] fifo_mem [2];
    logic          fifo_wr_sel, fifo_rd_sel;
    logic [1:0]    fifo_count, credit;
    logic          push, pop, last_hs;
    logic          unused_ctrl;

    // Only the start bit and the last-address field of the control word are used.
    assign unused_ctrl = ^{USR_tcm_control[31:7+AW], USR_tcm_control[5:0]};

    // start_arm only sets once bit6 has been seen low after reset, so a start bit
    // held high through reset cannot be mistaken for a fresh rising edge.
    assign start_pulse  = USR_tcm_control[6] & ~start_q & start_arm;
    assign start_accept = start_pulse & (state != RUN);

    assign pop     = M_AXIS_TVALID & M_AXIS_TREADY;
    assign push    = inflight;
    assign last_hs = (state == RUN) & pop & (out_idx == last_addr);

    assign M_AXIS_TVALID = (fifo_count != 2'd0);
    assign M_AXIS_TDATA  = fifo_mem[fifo_rd_sel];
    assign M_AXIS_TLAST  = M_AXIS_TVALID & (out_idx == last_addr);
    assign tcm_rd_addr   = rd_ptr;

    // A word leaving the FIFO this cycle frees its slot for the read issued now,
    // which keeps the stream gap-free at full TREADY without ever overflowing.
    assign credit    = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign tcm_rd_en = issuing & (credit < 2'd2) & ~rd_exhausted;

    // Start-bit edge detector and arm flag.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            start_q   <= 1'b0;
            start_arm <= 1'b0;
        end else begin
            start_q <= USR_tcm_control[6];
            if (!USR_tcm_control[6]) begin
                start_arm <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: a start in RUN is ignored, DONE can restart immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_pulse) state_nxt = RUN;
            RUN:     if (last_hs)     state_nxt = DONE;
            DONE:    if (start_pulse) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: status flags and read-issue permission.
    always_comb begin
        tcm_busy = 1'b0;
        tcm_done = 1'b0;
        issuing  = 1'b0;
        case (state)
            RUN: begin
                tcm_busy = 1'b1;
                issuing  = 1'b1;
            end
            DONE:    tcm_done = 1'b1;
            default: ;
        endcase
    end

    // Read pointer, output word index and packet length, all re-armed on an accepted start.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            last_addr    <= '0;
            rd_ptr       <= '0;
            out_idx      <= '0;
            rd_exhausted <= 1'b0;
            inflight     <= 1'b0;
        end else if (start_accept) begin
            last_addr    <= USR_tcm_control[7 +: AW];
            rd_ptr       <= '0;
            out_idx      <= '0;
            rd_exhausted <= 1'b0;
            inflight     <= 1'b0;
        end else begin
            inflight <= tcm_rd_en;
            if (tcm_rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (rd_ptr == last_addr) begin
                    rd_exhausted <= 1'b1;
                end
            end
            if (pop) begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

    // Two-entry output FIFO: captures BRAM data one cycle after each issue, pops on handshake.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_sel <= 1'b0;
            fifo_rd_sel <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_sel] <= tcm_rd_data;
                fifo_wr_sel           <= ~fifo_wr_sel;
            end
            if (pop) begin
                fifo_rd_sel <= ~fifo_rd_sel;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule
